// File: rtl/matvec8_part4_core.sv
// Streaming KxK signed matrix-by-vector multiplier (y = M*x) with valid/ready ports.
// One matrix and one vector are buffered; a matrix load is optional per transaction.
//
// state   | meaning
// IDLE    | waiting for the first word; new_matrix picks LOAD_M or LOAD_V
// LOAD_M  | accepting matrix words row-major, M[0][0]..M[K-1][K-1]
// LOAD_V  | accepting vector words x[0]..x[K-1]
// COMPUTE | one MAC per cycle over the columns of row r
// OUTPUT  | presenting y[r] until the sink accepts it
module matvec8_part4_core #(
    parameter int K  = 8,
    parameter int IW = 14,
    parameter int OW = 28
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic [IW-1:0] input_data,
    input  logic          new_matrix,
    output logic          output_valid,
    input  logic          output_ready,
    output logic [OW-1:0] output_data
);

    localparam int AW = $clog2(K * K);
    localparam int CW = $clog2(K);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_V,
        COMPUTE,
        OUTPUT
    } state_t;

    state_t state;

    logic [AW-1:0]        widx;
    logic [CW-1:0]        row;
    logic [CW-1:0]        col;
    logic signed [OW-1:0] acc;

    logic signed [IW-1:0] mat [K*K];
    logic signed [IW-1:0] vec [K];

    logic                   in_fire;
    logic                   out_fire;
    logic                   mat_we;
    logic                   vec_we;
    logic [AW-1:0]          mat_waddr;
    logic [CW-1:0]          vec_waddr;
    logic signed [2*IW-1:0] prod;
    logic signed [OW-1:0]   mac_sum;

    // new_matrix only matters while in_fire is set, so X on an idle bus never reaches state
    always_comb begin
        in_fire   = input_valid && input_ready;
        out_fire  = output_valid && output_ready;
        mat_we    = in_fire && (((state == IDLE) && new_matrix) || (state == LOAD_M));
        vec_we    = in_fire && (((state == IDLE) && !new_matrix) || (state == LOAD_V));
        mat_waddr = (state == IDLE) ? '0 : widx;
        vec_waddr = (state == IDLE) ? '0 : widx[CW-1:0];
        prod      = mat[{row, col}] * vec[col];
        mac_sum   = acc + OW'(prod);
    end

    // Operand storage deliberately survives reset so a stored matrix can be reused
    always_ff @(posedge clk) begin
        if (mat_we) begin
            mat[mat_waddr] <= input_data;
        end
        if (vec_we) begin
            vec[vec_waddr] <= input_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            widx         <= '0;
            row          <= '0;
            col          <= '0;
            acc          <= '0;
            input_ready  <= 1'b0;
            output_valid <= 1'b0;
            output_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    input_ready <= 1'b1;
                    if (in_fire) begin
                        widx  <= AW'(1);
                        state <= new_matrix ? LOAD_M : LOAD_V;
                    end
                end
                LOAD_M: begin
                    if (in_fire) begin
                        if (widx == AW'(K * K - 1)) begin
                            widx  <= '0;
                            state <= LOAD_V;
                        end else begin
                            widx <= widx + AW'(1);
                        end
                    end
                end
                LOAD_V: begin
                    if (in_fire) begin
                        if (widx == AW'(K - 1)) begin
                            widx        <= '0;
                            input_ready <= 1'b0;
                            row         <= '0;
                            col         <= '0;
                            acc         <= '0;
                            state       <= COMPUTE;
                        end else begin
                            widx <= widx + AW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    acc <= mac_sum;
                    col <= col + CW'(1);
                    if (col == CW'(K - 1)) begin
                        output_data  <= mac_sum;
                        output_valid <= 1'b1;
                        state        <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        output_valid <= 1'b0;
                        acc          <= '0;
                        col          <= '0;
                        if (row == CW'(K - 1)) begin
                            row         <= '0;
                            input_ready <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            row   <= row + CW'(1);
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec8_part4_core.sv
// Scoreboard bench for matvec8_part4_core: a software model pushes expected y values
// when a vector is sent, a negedge monitor pops and compares on every output transfer.
module tb_matvec8_part4_core;

    localparam int K  = 8;
    localparam int IW = 14;
    localparam int OW = 28;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [IW-1:0] input_data = '0;
    logic          new_matrix = 1'b0;
    logic          output_valid;
    logic          output_ready = 1'b0;
    logic [OW-1:0] output_data;

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;
    bit rand_in = 1'b0;
    int n_out = 0;
    int n_exp = 0;

    logic [OW-1:0]        exp_q[$];
    logic signed [IW-1:0] model_m [K*K];
    logic signed [IW-1:0] model_v [K];
    logic [OW-1:0]        hold;

    always #5 clk = ~clk;

    matvec8_part4_core #(.K(K), .IW(IW), .OW(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .new_matrix   (new_matrix),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench aborted on a stalled handshake");
    endtask

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       output_ready = 1'b1;
            1:       output_ready = 1'($urandom_range(0, 1));
            default: output_ready = 1'b0;
        endcase
    end

    // Both output_valid and output_ready are steady through the next rising edge here
    always @(negedge clk) begin
        if (reset && output_valid && output_ready) begin
            if (exp_q.size() == 0) begin
                chk_val("out_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                chk_val("y", 32'(output_data), 32'(exp_q.pop_front()));
                n_out++;
            end
        end
    end

    task automatic send_word(input logic [IW-1:0] d, input logic nm);
        int  guard = 0;
        bit  done = 1'b0;
        while (!done) begin
            if (rand_in && ($urandom_range(0, 1) == 0)) begin
                input_valid = 1'b0;
                input_data  = 'x;
                new_matrix  = 1'bx;
            end else begin
                input_valid = 1'b1;
                input_data  = d;
                new_matrix  = nm;
            end
            done = input_valid && input_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 5000) begin
                chk_val("in_timeout", 32'(guard), 32'd0);
                finish_now();
            end
        end
        input_valid = 1'b0;
        input_data  = 'x;
        new_matrix  = 1'bx;
    endtask

    task automatic push_expected();
        longint s;
        for (int r = 0; r < K; r++) begin
            s = 0;
            for (int c = 0; c < K; c++) begin
                s += longint'(model_m[r*K+c]) * longint'(model_v[c]);
            end
            exp_q.push_back(s[OW-1:0]);
            n_exp++;
        end
    endtask

    task automatic run_tx(input bit load, input bit force_nm);
        logic nm;
        if (load) begin
            for (int i = 0; i < K*K; i++) begin
                nm = (i == 0) ? 1'b1 : (force_nm ? 1'b1 : 1'($urandom_range(0, 1)));
                send_word(model_m[i], nm);
            end
        end
        for (int c = 0; c < K; c++) begin
            if (!load && c == 0) nm = 1'b0;
            else nm = force_nm ? 1'b1 : 1'($urandom_range(0, 1));
            send_word(model_v[c], nm);
        end
        push_expected();
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk_val("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!output_valid && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk_val("valid_seen", 32'(output_valid), 32'd1);
    endtask

    task automatic rand_vec();
        for (int c = 0; c < K; c++) model_v[c] = IW'($urandom_range(0, (1 << IW) - 1));
    endtask

    task automatic rand_mat();
        for (int i = 0; i < K*K; i++) model_m[i] = IW'($urandom_range(0, (1 << IW) - 1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_in_ready", 32'(input_ready), 32'd0);
        chk_val("rst_out_valid", 32'(output_valid), 32'd0);
        chk_val("rst_out_data", 32'(output_data), 32'd0);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_val("idle_in_ready", 32'(input_ready), 32'd1);

        // identity matrix, then reuse with a negative vector
        for (int i = 0; i < K*K; i++) model_m[i] = ((i / K) == (i % K)) ? IW'(1) : IW'(0);
        for (int c = 0; c < K; c++) model_v[c] = IW'(c + 1);
        run_tx(1'b1, 1'b0);
        wait_drain();
        for (int c = 0; c < K; c++) model_v[c] = IW'(-(c + 1));
        run_tx(1'b0, 1'b0);
        wait_drain();

        // extremes: wrapped results 0 and 0x0010000
        for (int i = 0; i < K*K; i++) model_m[i] = IW'(-8192);
        for (int c = 0; c < K; c++) model_v[c] = IW'(-8192);
        run_tx(1'b1, 1'b0);
        wait_drain();
        for (int i = 0; i < K*K; i++) model_m[i] = IW'(8191);
        run_tx(1'b1, 1'b0);
        wait_drain();

        // backpressure on y[0]
        rand_mat();
        run_tx(1'b1, 1'b0);
        wait_drain();
        ready_mode = 2;
        rand_vec();
        run_tx(1'b0, 1'b0);
        wait_valid();
        hold = output_data;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk_val("bp_data", 32'(output_data), 32'(hold));
            chk_val("bp_valid", 32'(output_valid), 32'd1);
            chk_val("bp_in_ready", 32'(input_ready), 32'd0);
        end
        ready_mode = 0;
        wait_drain();

        // new_matrix=1 on non-first words of a vector-only transaction
        rand_vec();
        run_tx(1'b0, 1'b1);
        wait_drain();

        // async reset in the middle of a matrix load
        rand_mat();
        for (int i = 0; i < 30; i++) send_word(model_m[i], (i == 0) ? 1'b1 : 1'b0);
        #3 reset = 1'b0;
        #1;
        chk_val("rstm_out_valid", 32'(output_valid), 32'd0);
        chk_val("rstm_in_ready", 32'(input_ready), 32'd0);
        #3 reset = 1'b1;
        rand_mat();
        rand_vec();
        run_tx(1'b1, 1'b0);
        wait_drain();

        // async reset while a result is pending
        ready_mode = 2;
        rand_vec();
        run_tx(1'b0, 1'b0);
        wait_valid();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk_val("rsto_out_valid", 32'(output_valid), 32'd0);
        chk_val("rsto_out_data", 32'(output_data), 32'd0);
        exp_q.delete();
        n_exp -= K;
        ready_mode = 0;
        #2 reset = 1'b1;
        rand_vec();
        run_tx(1'b0, 1'b0);
        wait_drain();

        // random throttling with mixed reloads
        rand_in = 1'b1;
        ready_mode = 1;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                rand_mat();
                rand_vec();
                run_tx(1'b1, 1'b0);
            end else begin
                rand_vec();
                run_tx(1'b0, 1'b0);
            end
        end
        wait_drain();
        rand_in = 1'b0;
        ready_mode = 0;

        repeat (5) @(posedge clk);
        #1;
        chk_val("queue_empty", 32'(exp_q.size()), 32'd0);
        chk_val("out_count", 32'(n_out), 32'(n_exp));
        chk_val("final_valid", 32'(output_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
